echo_rr_arbiter: RTL and testbench
==================================

# echo_rr_arbiter

Two-client round-robin front end for the echo datapath. Two requesters issue `say(v)` calls; the block grants one per cycle into the single downstream Echo `say` port. It records the winner in an in-order tag queue and steers each returning `heard(v)` back to the client that issued it. It sits between the clients and one Echo instance and shares that instance's FIFO without losing response ordering.

## Interface
- `WIDTH`, 32: payload width of `say$v` / `heard$v`.
- `DEPTH`, 4: maximum outstanding requests, which is also the tag-queue depth; power of 2, ≥2.
- `CLK`  in  1  sole clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `c0$say__ENA` / `c0$say$v` / `c0$say__RDY`  in / in / out  1 / WIDTH / 1  client 0 request.
- `c1$say__ENA` / `c1$say$v` / `c1$say__RDY`  in / in / out  1 / WIDTH / 1  client 1 request.
- `d$say__ENA` / `d$say$v` / `d$say__RDY`  out / out / in  1 / WIDTH / 1  to Echo `sout$say`.
- `d$heard__ENA` / `d$heard$v` / `d$heard__RDY`  in / in / out  1 / WIDTH / 1  from Echo `ind$heard`.
- `c0$heard__ENA` / `c0$heard$v` / `c0$heard__RDY`  out / out / in  1 / WIDTH / 1  response to client 0.
- `c1$heard__ENA` / `c1$heard$v` / `c1$heard__RDY`  out / out / in  1 / WIDTH / 1  response to client 1.
- `outstanding`  out  $clog2(DEPTH+1)  current tag-queue occupancy.
- `orphan`  out  1  sticky error: Echo produced `heard` while the tag queue was empty.

## Operation
- **Transfer rule.** A method transfer occurs in any cycle where its ENA and RDY are both 1. Clients must not drive ENA from the other client's RDY.
- **State registers.**
  - `prio`: 1 bit, the favoured client.
  - Tag queue: DEPTH×1 bit, with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - `count`: occupancy, 0..DEPTH.
  - `orphan`: sticky error flag.
- **Request arbitration.**
  - `ok = d$say__RDY & (count != DEPTH)`.
  - Client `prio`: `RDY = ok`.
  - Other client: `RDY = ok & ~c<prio>$say__ENA`.
- **Grant.**
  - `d$say__ENA` = (c0 transfer) | (c1 transfer).
  - `d$say$v` = payload of the granted client; it is 0 when there is no grant.
  - On a grant to client i: push tag i, then `prio <= ~i`.
  - With no grant, `prio` holds.
- **Full.** At `count == DEPTH`, both `say__RDY` are 0, even if a pop occurs in the same cycle. There is no bypass.
- **Response routing.** Let `t` be the head tag.
  - `d$heard__RDY = (count != 0) & c<t>$heard__RDY`.
  - `c<t>$heard__ENA = d$heard__ENA & (count != 0)`; the other client's ENA is 0.
  - Both `c*$heard$v = d$heard$v`, passed through.
  - Pop on `d$heard__ENA & d$heard__RDY`.
- **Empty.** At `count == 0`, `d$heard__RDY = 0` and neither client's heard ENA is asserted. If `d$heard__ENA = 1` while empty, `orphan` is set to 1 and held until reset.
- **Push and pop in the same cycle.** `count` is unchanged and both pointers advance.
- **count update.** +1 on push only, −1 on pop only. Overflow and underflow are impossible by the guards above.

## Timing
- Arbitration, grant and response routing are combinational, with zero-cycle latency from client to Echo and from Echo to client.
- `count`, pointers, tag entries, `prio` and `orphan` update on the rising edge of CLK.
- A grant's tag is visible as head data no earlier than the next cycle. Echo's own one-cycle FIFO latency guarantees this.
- **Reset values** (asynchronous on `nRST` low; outputs settle without a clock):
  - `count = 0`, pointers = 0, `prio = 0`, `orphan = 0`.
  - Therefore `outstanding = 0`, `d$heard__RDY = 0`, `c*$heard__ENA = 0`, `d$say__ENA = 0`.
- **Reset mid-operation.** All outstanding tags are discarded. The Echo instance must share `nRST` so that its in-flight data is dropped consistently.
- No state changes while `nRST` is low; normal operation resumes at the first rising edge after `nRST` goes high.

## Test plan
- **Reset check.** Assert `nRST` low mid-stream with `count = 3` → `outstanding = 0`, `orphan = 0` and `prio = 0` with no clock. After release, c0 is favoured.
- **Contention.** c0 and c1 both hold ENA continuously, c0 payloads 0x100, 0x101, … and c1 payloads 0x200, 0x201, …, all `heard__RDY = 1` → `d$say$v` alternates 0x100, 0x200, 0x101, 0x200+1, …. c0 receives only 0x1xx and c1 only 0x2xx, both in order.
- **Full.** With DEPTH = 4, issue 4 c0 requests while Echo `heard` is blocked (`c0$heard__RDY = 0`) → `outstanding = 4` and both `say__RDY = 0`. Raise `c0$heard__RDY` → one pop per cycle. `say__RDY` returns only in the cycle after the first pop.
- **Head-of-line block.** Queue tags [c1, c0]; `c1$heard__RDY = 0`, `c0$heard__RDY = 1` → `d$heard__RDY = 0` and c0 gets nothing until c1 accepts its response.
- **Simultaneous push and pop.** At `count = 2`, perform a push and a pop in the same cycle → `count` stays 2, and the pointers wrap correctly through index 3 → 0.
- **Orphan.** Force `d$heard__ENA = 1` with `count = 0` → `orphan` rises on the next edge, stays 1 through further traffic, and clears only on `nRST`.

Source files
------------

// File: rtl/echo_rr_arbiter.sv
// rtl/echo_rr_arbiter.sv - two-client round-robin front end sharing one Echo instance
//
// Purpose: grants at most one client say() per cycle into the downstream Echo,
// records the winner in an in-order tag queue, and steers each returning heard()
// to the client that issued it.
//
// Ports:
//   clk_i, rst_ni                       clock (rising edge), async active-low reset
//   cN_say_ena_i / cN_say_v_i / cN_say_rdy_o       client N request (N = 0, 1)
//   d_say_ena_o / d_say_v_o / d_say_rdy_i          request into Echo
//   d_heard_ena_i / d_heard_v_i / d_heard_rdy_o    response from Echo
//   cN_heard_ena_o / cN_heard_v_o / cN_heard_rdy_i response to client N
//   outstanding_o                       tag-queue occupancy
//   orphan_o                            sticky: Echo responded with no outstanding tag
module echo_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       c0_say_ena_i,
  input  logic [WIDTH-1:0]           c0_say_v_i,
  output logic                       c0_say_rdy_o,
  input  logic                       c1_say_ena_i,
  input  logic [WIDTH-1:0]           c1_say_v_i,
  output logic                       c1_say_rdy_o,
  output logic                       d_say_ena_o,
  output logic [WIDTH-1:0]           d_say_v_o,
  input  logic                       d_say_rdy_i,
  input  logic                       d_heard_ena_i,
  input  logic [WIDTH-1:0]           d_heard_v_i,
  output logic                       d_heard_rdy_o,
  output logic                       c0_heard_ena_o,
  output logic [WIDTH-1:0]           c0_heard_v_o,
  input  logic                       c0_heard_rdy_i,
  output logic                       c1_heard_ena_o,
  output logic [WIDTH-1:0]           c1_heard_v_o,
  input  logic                       c1_heard_rdy_i,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic                       orphan_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic             prio_q, prio_d;
  logic [DEPTH-1:0] tags_q, tags_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             orphan_q, orphan_d;

  logic ok, nonempty, head_tag;
  logic c0_grant, c1_grant, push, pop;

  // No full bypass: a pop in the same cycle does not reopen the request side.
  assign ok       = d_say_rdy_i & (count_q != CW'(DEPTH));
  assign nonempty = (count_q != '0);
  assign head_tag = tags_q[rd_ptr_q];

  always_comb begin
    // The favoured client sees ok directly; the other yields whenever the
    // favoured one is requesting, so at most one grant happens per cycle.
    c0_say_rdy_o = ok & (~prio_q | ~c1_say_ena_i);
    c1_say_rdy_o = ok & ( prio_q | ~c0_say_ena_i);
    c0_grant     = c0_say_ena_i & c0_say_rdy_o;
    c1_grant     = c1_say_ena_i & c1_say_rdy_o;
    push         = c0_grant | c1_grant;
    d_say_ena_o  = push;
    d_say_v_o    = '0;
    if (c0_grant) begin
      d_say_v_o = c0_say_v_i;
    end else if (c1_grant) begin
      d_say_v_o = c1_say_v_i;
    end
  end

  always_comb begin
    // Responses only flow to the head-tag owner; a stalled owner blocks the
    // other client (head-of-line) to keep the shared Echo FIFO in order.
    d_heard_rdy_o  = nonempty & (head_tag ? c1_heard_rdy_i : c0_heard_rdy_i);
    c0_heard_ena_o = d_heard_ena_i & nonempty & ~head_tag;
    c1_heard_ena_o = d_heard_ena_i & nonempty &  head_tag;
    c0_heard_v_o   = d_heard_v_i;
    c1_heard_v_o   = d_heard_v_i;
    pop            = d_heard_ena_i & d_heard_rdy_o;
  end

  always_comb begin
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    prio_d   = prio_q;
    orphan_d = orphan_q | (d_heard_ena_i & ~nonempty);
    if (push) begin
      tags_d[wr_ptr_q] = c1_grant;
      wr_ptr_d         = wr_ptr_q + PW'(1);
      prio_d           = c0_grant;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q   <= 1'b0;
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      orphan_q <= orphan_d;
    end
  end

  assign outstanding_o = count_q;
  assign orphan_o      = orphan_q;

endmodule

// File: tb/tb_echo_rr_arbiter.sv
// tb/tb_echo_rr_arbiter.sv - self-checking bench for echo_rr_arbiter with a queue-based reference model
module tb_echo_rr_arbiter;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         c0_say_ena, c1_say_ena, c0_say_rdy, c1_say_rdy;
  logic [W-1:0] c0_say_v, c1_say_v;
  logic         d_say_ena, d_say_rdy;
  logic [W-1:0] d_say_v;
  logic         d_heard_ena, d_heard_rdy;
  logic [W-1:0] d_heard_v;
  logic         c0_heard_ena, c1_heard_ena, c0_heard_rdy, c1_heard_rdy;
  logic [W-1:0] c0_heard_v, c1_heard_v;
  logic [2:0]   outstanding;
  logic         orphan;

  always #5 clk = ~clk;

  echo_rr_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .c0_say_ena_i(c0_say_ena), .c0_say_v_i(c0_say_v), .c0_say_rdy_o(c0_say_rdy),
    .c1_say_ena_i(c1_say_ena), .c1_say_v_i(c1_say_v), .c1_say_rdy_o(c1_say_rdy),
    .d_say_ena_o(d_say_ena), .d_say_v_o(d_say_v), .d_say_rdy_i(d_say_rdy),
    .d_heard_ena_i(d_heard_ena), .d_heard_v_i(d_heard_v), .d_heard_rdy_o(d_heard_rdy),
    .c0_heard_ena_o(c0_heard_ena), .c0_heard_v_o(c0_heard_v), .c0_heard_rdy_i(c0_heard_rdy),
    .c1_heard_ena_o(c1_heard_ena), .c1_heard_v_o(c1_heard_v), .c1_heard_rdy_i(c1_heard_rdy),
    .outstanding_o(outstanding), .orphan_o(orphan)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: client-id queue for outstanding requests, the Echo's
  // payload FIFO, per-client expected responses, favoured client, sticky flag.
  int           tagq[$];
  logic [W-1:0] echoq[$];
  logic [W-1:0] exp0[$];
  logic [W-1:0] exp1[$];
  int           prio;
  bit           orph;
  bit           g0, g1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    tagq.delete();
    echoq.delete();
    exp0.delete();
    exp1.delete();
    prio = 0;
    orph = 0;
  endtask

  // Behaves as the Echo instance: offers the oldest in-flight payload.
  task automatic drive_echo(input bit en);
    if (en && echoq.size() > 0) begin
      d_heard_ena = 1'b1;
      d_heard_v   = echoq[0];
    end else begin
      d_heard_ena = 1'b0;
      d_heard_v   = $urandom;
    end
  endtask

  // Called with inputs freshly driven just after a rising edge: checks every
  // output against the model, advances the model, and moves past the next edge.
  task automatic step();
    bit           ok, r0, r1, ne, hr;
    int           head;
    logic [W-1:0] dv, want;
    #1;
    ok   = d_say_rdy && (tagq.size() < D);
    r0   = ok && (prio == 0 || !c1_say_ena);
    r1   = ok && (prio == 1 || !c0_say_ena);
    g0   = c0_say_ena && r0;
    g1   = c1_say_ena && r1;
    dv   = g0 ? c0_say_v : (g1 ? c1_say_v : '0);
    ne   = tagq.size() > 0;
    head = ne ? tagq[0] : 0;
    hr   = ne && (head == 0 ? c0_heard_rdy : c1_heard_rdy);
    chk("c0_say_rdy", c0_say_rdy, r0);
    chk("c1_say_rdy", c1_say_rdy, r1);
    chk("d_say_ena", d_say_ena, g0 | g1);
    chk("d_say_v", d_say_v, dv);
    chk("d_heard_rdy", d_heard_rdy, hr);
    chk("c0_heard_ena", c0_heard_ena, d_heard_ena && ne && head == 0);
    chk("c1_heard_ena", c1_heard_ena, d_heard_ena && ne && head == 1);
    chk("outstanding", outstanding, tagq.size());
    chk("orphan", orphan, orph);
    if (d_heard_ena && hr) begin
      if (head == 0) begin
        want = exp0.pop_front();
        chk("c0_heard_v", c0_heard_v, want);
      end else begin
        want = exp1.pop_front();
        chk("c1_heard_v", c1_heard_v, want);
      end
      void'(tagq.pop_front());
      void'(echoq.pop_front());
    end
    if (d_heard_ena && !ne) orph = 1;
    if (g0) begin
      tagq.push_back(0); echoq.push_back(c0_say_v); exp0.push_back(c0_say_v); prio = 1;
    end else if (g1) begin
      tagq.push_back(1); echoq.push_back(c1_say_v); exp1.push_back(c1_say_v); prio = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    c0_say_ena = 0; c1_say_ena = 0; d_say_rdy = 1;
    c0_heard_rdy = 1; c1_heard_rdy = 1;
    for (int i = 0; i < 20 && tagq.size() > 0; i++) begin
      drive_echo(1);
      step();
    end
    drive_echo(0);
    #1;
    chk("drain_empty", outstanding, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    rst_n = 0; d_say_rdy = 1;
    c0_say_ena = 0; c1_say_ena = 0; c0_say_v = '0; c1_say_v = '0;
    c0_heard_rdy = 1; c1_heard_rdy = 1; d_heard_ena = 1; d_heard_v = '0;
    model_reset();

    // Reset values settle before any clock edge.
    #3;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_d_heard_rdy", d_heard_rdy, 0);
    chk("rst_c0_heard_ena", c0_heard_ena, 0);
    chk("rst_c1_heard_ena", c1_heard_ena, 0);
    chk("rst_d_say_ena", d_say_ena, 0);
    chk("rst_orphan", orphan, 0);
    d_heard_ena = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Contention: both clients request every cycle; grants must alternate.
    c0_say_ena = 1; c1_say_ena = 1; n0 = 0; n1 = 0;
    for (int k = 0; k < 12; k++) begin
      c0_say_v = 32'h100 + n0;
      c1_say_v = 32'h200 + n1;
      drive_echo(1);
      #1;
      chk("contention_v", d_say_v, (k % 2 == 0) ? 32'h100 + k / 2 : 32'h200 + k / 2);
      step();
      if (g0) n0++;
      if (g1) n1++;
    end
    drain();

    // Full: four c0 requests with the head response blocked.
    c0_heard_rdy = 0; c0_say_ena = 1;
    for (int i = 0; i < 4; i++) begin
      c0_say_v = $urandom;
      drive_echo(1);
      step();
    end
    c1_say_ena = 1;
    drive_echo(1);
    #1;
    chk("full_outstanding", outstanding, 4);
    chk("full_c0_rdy", c0_say_rdy, 0);
    chk("full_c1_rdy", c1_say_rdy, 0);
    step();
    c0_heard_rdy = 1;
    drive_echo(1);
    #1;
    chk("full_pop_d_heard_rdy", d_heard_rdy, 1);
    chk("full_pop_c1_rdy", c1_say_rdy, 0);
    step();
    drive_echo(1);
    #1;
    chk("after_pop_c1_rdy", c1_say_rdy, 1);
    step();
    drain();

    // Head-of-line: tags [c1, c0], c1 not accepting.
    c1_say_ena = 1; c1_say_v = 32'hC1; drive_echo(0); step();
    c1_say_ena = 0; c0_say_ena = 1; c0_say_v = 32'hC0; step();
    c0_say_ena = 0; c1_heard_rdy = 0; c0_heard_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      drive_echo(1);
      #1;
      chk("hol_d_heard_rdy", d_heard_rdy, 0);
      chk("hol_c0_heard_ena", c0_heard_ena, 0);
      step();
    end
    c1_heard_rdy = 1;
    drive_echo(1); step();
    drive_echo(1);
    #1;
    chk("hol_c0_after", c0_heard_ena, 1);
    step();
    drain();

    // Simultaneous push and pop at count 2, long enough to wrap the pointers.
    c0_say_ena = 1;
    for (int i = 0; i < 2; i++) begin
      c0_say_v = $urandom; drive_echo(0); step();
    end
    for (int i = 0; i < 6; i++) begin
      c0_say_v = $urandom; drive_echo(1); step();
      chk("pushpop_count", outstanding, 2);
    end
    drain();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      c0_say_ena   = $urandom_range(0, 1);
      c1_say_ena   = $urandom_range(0, 1);
      c0_say_v     = $urandom;
      c1_say_v     = $urandom;
      d_say_rdy    = ($urandom_range(0, 3) != 0);
      c0_heard_rdy = ($urandom_range(0, 3) != 0);
      c1_heard_rdy = ($urandom_range(0, 3) != 0);
      drive_echo($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    // Orphan: heard while empty sets a sticky flag.
    d_heard_ena = 1; d_heard_v = 32'hDEAD;
    #1;
    chk("orphan_before", orphan, 0);
    step();
    d_heard_ena = 0;
    #1;
    chk("orphan_set", orphan, 1);
    for (int i = 0; i < 8; i++) begin
      c0_say_ena = $urandom_range(0, 1);
      c1_say_ena = $urandom_range(0, 1);
      c0_say_v = $urandom; c1_say_v = $urandom;
      drive_echo(1);
      step();
    end
    drain();

    // Reset mid-operation with three outstanding.
    c0_say_ena = 1;
    for (int i = 0; i < 3; i++) begin
      c0_say_v = $urandom; drive_echo(0); step();
    end
    c0_say_ena = 0;
    drive_echo(0);
    #1;
    chk("pre_reset_outstanding", outstanding, 3);
    rst_n = 0;
    #1;
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_orphan", orphan, 0);
    chk("midrst_d_heard_rdy", d_heard_rdy, 0);
    chk("midrst_d_say_ena", d_say_ena, 0);
    c0_say_ena = 1; c1_say_ena = 1;
    #1;
    chk("midrst_prio_c0_rdy", c0_say_rdy, 1);
    chk("midrst_prio_c1_rdy", c1_say_rdy, 0);
    c0_say_ena = 0; c1_say_ena = 0;
    @(posedge clk); #1;
    chk("midrst_hold", outstanding, 0);
    rst_n = 1;
    model_reset();
    @(posedge clk); #1;
    c0_say_ena = 1; c1_say_ena = 1; c0_say_v = 32'hA0; c1_say_v = 32'hB0;
    drive_echo(0);
    #1;
    chk("post_rst_c0_favoured", d_say_v, 32'hA0);
    step();
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
